// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
// Requests use a req/gnt handshake; responses return in request order with variable latency.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: credit-limited in-order fetch, small instruction FIFO with bypass,
// IF/ID pipeline register with stall hold and early-branch redirect that drops in-flight words.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2,
    parameter logic [31:0] NOP_INST        = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    if_stage_if.master        io_imem,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [31:0]       i_branch_addr,
    output logic              o_id_valid,
    output logic [31:0]       o_id_pc,
    output logic [31:0]       o_id_inst
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW  = $clog2(FIFO_DEPTH + 1);
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]    r_pc_fetch;
    logic [OW-1:0]  r_outstanding;
    logic [OW-1:0]  r_drop_cnt;

    logic [31:0]    r_pq [MAX_OUTSTANDING];
    logic [PAW-1:0] r_pq_wr;
    logic [PAW-1:0] r_pq_rd;

    logic [31:0]    r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]    r_fifo_inst [FIFO_DEPTH];
    logic [FAW-1:0] r_fifo_wr;
    logic [FAW-1:0] r_fifo_rd;
    logic [FW-1:0]  r_fifo_cnt;

    logic           r_id_valid;
    logic [31:0]    r_id_pc;
    logic [31:0]    r_id_inst;

    logic           w_redirect;
    logic           w_credit;
    logic           w_req;
    logic           w_fire;
    logic           w_rsp;
    logic           w_rsp_keep;
    logic [31:0]    w_rsp_pc;
    logic           w_id_load;
    logic           w_fifo_empty;
    logic           w_pop;
    logic           w_bypass;
    logic           w_push;

    function automatic logic [FAW-1:0] fifo_ptr_inc(input logic [FAW-1:0] p);
        if (p == FAW'(FIFO_DEPTH - 1)) return '0;
        return p + FAW'(1);
    endfunction

    function automatic logic [PAW-1:0] pq_ptr_inc(input logic [PAW-1:0] p);
        if (p == PAW'(MAX_OUTSTANDING - 1)) return '0;
        return p + PAW'(1);
    endfunction

    // A request is only offered when both an outstanding slot and a FIFO slot are reserved for it,
    // so a returning word always has somewhere to go.
    assign w_redirect = i_branch_taken && !i_stall;
    assign w_credit   = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                        ((int'(r_outstanding) + int'(r_fifo_cnt)) < FIFO_DEPTH);
    assign w_req      = !rst && !w_redirect && w_credit;
    assign w_fire     = w_req && io_imem.imem_gnt;

    assign w_rsp      = io_imem.imem_rvalid && (r_outstanding != '0);
    assign w_rsp_keep = w_rsp && (r_drop_cnt == '0) && !w_redirect;
    assign w_rsp_pc   = r_pq[r_pq_rd];

    assign w_id_load    = !i_stall && !w_redirect;
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_pop        = w_id_load && !w_fifo_empty;
    assign w_bypass     = w_id_load && w_fifo_empty && w_rsp_keep;
    assign w_push       = w_rsp_keep && !w_bypass;

    assign io_imem.imem_req  = w_req;
    assign io_imem.imem_addr = r_pc_fetch;

    assign o_id_valid = r_id_valid;
    assign o_id_pc    = r_id_pc;
    assign o_id_inst  = r_id_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_fetch    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pq_wr       <= '0;
            r_pq_rd       <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
            r_fifo_cnt    <= '0;
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_inst     <= NOP_INST;
        end else begin
            if (w_redirect)
                r_pc_fetch <= {i_branch_addr[31:2], 2'b00};
            else if (w_fire)
                r_pc_fetch <= r_pc_fetch + 32'd4;

            r_outstanding <= r_outstanding + OW'(w_fire) - OW'(w_rsp);
            if (w_fire) r_pq_wr <= pq_ptr_inc(r_pq_wr);
            if (w_rsp)  r_pq_rd <= pq_ptr_inc(r_pq_rd);

            // Every request still in flight after a redirect belongs to the old path.
            if (w_redirect)
                r_drop_cnt <= r_outstanding - OW'(w_rsp);
            else if (w_rsp && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - OW'(1);

            if (w_redirect) begin
                r_fifo_wr  <= '0;
                r_fifo_rd  <= '0;
                r_fifo_cnt <= '0;
            end else begin
                if (w_push) r_fifo_wr <= fifo_ptr_inc(r_fifo_wr);
                if (w_pop)  r_fifo_rd <= fifo_ptr_inc(r_fifo_rd);
                r_fifo_cnt <= r_fifo_cnt + FW'(w_push) - FW'(w_pop);
            end

            if (!i_stall) begin
                if (w_pop) begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= r_fifo_pc[r_fifo_rd];
                    r_id_inst  <= r_fifo_inst[r_fifo_rd];
                end else if (w_bypass) begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= w_rsp_pc;
                    r_id_inst  <= io_imem.imem_rdata;
                end else begin
                    r_id_valid <= 1'b0;
                    r_id_inst  <= NOP_INST;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_pq[r_pq_wr] <= r_pc_fetch;
        if (w_push) begin
            r_fifo_pc[r_fifo_wr]   <= w_rsp_pc;
            r_fifo_inst[r_fifo_wr] <= io_imem.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(io_imem.imem_rvalid && (r_outstanding == '0)));
            assert (int'(r_outstanding) <= MAX_OUTSTANDING);
            assert (int'(r_fifo_cnt) <= FIFO_DEPTH);
            assert (r_drop_cnt <= r_outstanding);
            assert (r_id_valid || (r_id_inst == NOP_INST));
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: variable-latency memory responder plus a queue-based reference model of
// fetched-but-unconsumed words, driven by directed steps and a randomized section.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] baddr = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    if_stage_if imem ();

    if_stage #(
        .RESET_PC(RESET_PC),
        .MAX_OUTSTANDING(2),
        .FIFO_DEPTH(2),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_imem(imem),
        .i_stall(stall),
        .i_branch_taken(bt),
        .i_branch_addr(baddr),
        .o_id_valid(id_valid),
        .o_id_pc(id_pc),
        .o_id_inst(id_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    req_t  mq[$];
    word_t avail[$];
    int    cyc, epoch, lat, gmode, gtog;
    logic        m_valid;
    logic [31:0] m_pc, m_inst, m_fetch;
    int    n_chk, n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'h1;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        avail.delete();
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_inst  = NOP;
        m_fetch = RESET_PC;
    endtask

    // One clock: drive memory response/grant, check outputs, advance across the edge, update model.
    task automatic cycle();
        logic  rv, g, acc, redir, keep, exp_req;
        req_t  e;
        word_t w;
        rv = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        case (gmode)
            0: g = 1'b1;
            1: begin g = ((gtog % 3) != 1); gtog++; end
            default: g = 1'($urandom_range(0, 1));
        endcase
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rv ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        imem.imem_gnt    = g;
        #1;
        redir   = bt && !stall && !rst;
        exp_req = !rst && !redir && (mq.size() < 2) && ((mq.size() + avail.size()) < 2);
        chk1("imem_req", imem.imem_req, exp_req);
        if (imem.imem_req) chk32("imem_addr", imem.imem_addr, m_fetch);
        chk1("id_valid", id_valid, m_valid);
        chk32("id_pc", id_pc, m_pc);
        chk32("id_inst", id_inst, m_inst);
        chk1("outstanding_le_2", mq.size() <= 2, 1'b1);
        acc = imem.imem_req && g;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            keep = 1'b0;
            w.pc = 32'h0;
            w.inst = 32'h0;
            if (rv) begin
                e      = mq.pop_front();
                keep   = (e.epoch == epoch) && !redir;
                w.pc   = e.addr;
                w.inst = mem_word(e.addr);
            end
            if (acc) begin
                e.addr  = m_fetch;
                e.due   = cyc + lat;
                e.epoch = epoch;
                mq.push_back(e);
                m_fetch = m_fetch + 32'd4;
            end
            if (stall) begin
                if (keep) avail.push_back(w);
            end else if (redir) begin
                avail.delete();
                m_valid = 1'b0;
                m_inst  = NOP;
                epoch++;
                m_fetch = {baddr[31:2], 2'b00};
            end else begin
                if (keep) avail.push_back(w);
                if (avail.size() > 0) begin
                    w       = avail.pop_front();
                    m_valid = 1'b1;
                    m_pc    = w.pc;
                    m_inst  = w.inst;
                end else begin
                    m_valid = 1'b0;
                    m_inst  = NOP;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; epoch = 0; lat = 1; gmode = 0; gtog = 0;
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        repeat (3) cycle();
        chk1("rst_id_valid", id_valid, 1'b0);
        chk32("rst_id_pc", id_pc, 32'h0);
        chk32("rst_id_inst", id_inst, NOP);

        // 1-cycle memory: first instruction two cycles after reset release
        rst = 1'b0;
        cycle(); cycle();
        chk1("lat_id_valid", id_valid, 1'b1);
        chk32("lat_id_pc", id_pc, 32'h0);
        cycle(); cycle();
        chk32("seq_id_pc8", id_pc, 32'h8);

        // Stall holds IF/ID, release continues without gap
        stall = 1'b1;
        repeat (3) begin
            cycle();
            chk32("stall_hold_pc", id_pc, 32'h8);
            chk32("stall_hold_inst", id_inst, 32'h9);
        end
        stall = 1'b0;
        cycle();
        chk32("release_pc12", id_pc, 32'hC);
        cycle();
        chk32("release_pc16", id_pc, 32'h10);
        chk1("release_valid", id_valid, 1'b1);

        // Redirect with two requests in flight
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 2) break;
            cycle();
        end
        chk32("two_in_flight", 32'(mq.size()), 32'd2);
        bt = 1'b1; baddr = 32'h103;
        cycle();
        bt = 1'b0;
        chk32("redir_addr", imem.imem_addr, 32'h100);
        chk1("redir_bubble", id_valid, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (id_valid) break;
            cycle();
        end
        chk1("redir_wait_valid", id_valid, 1'b1);
        chk32("redir_target_pc", id_pc, 32'h100);
        chk32("redir_target_inst", id_inst, 32'h101);

        // Branch during stall is ignored, then taken once stall drops
        stall = 1'b1; bt = 1'b1; baddr = 32'h200;
        cycle();
        chk1("stall_branch_ignored", imem.imem_addr != 32'h200, 1'b1);
        stall = 1'b0;
        cycle();
        bt = 1'b0;
        chk32("redir2_addr", imem.imem_addr, 32'h200);

        // 3-cycle latency with grant toggling 1,0,1
        gmode = 1;
        repeat (30) cycle();

        // PC wrap at the top of the address space
        gmode = 0; lat = 1;
        bt = 1'b1; baddr = 32'hFFFF_FFFE;
        cycle();
        bt = 1'b0;
        chk32("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
        repeat (6) cycle();

        // Randomized stall / branch / grant / latency
        gmode = 2;
        repeat (400) begin
            stall = ($urandom_range(0, 3) == 0);
            bt    = ($urandom_range(0, 19) == 0);
            baddr = $urandom;
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
            cycle();
        end
        stall = 1'b0; bt = 1'b0;

        // Reset mid-stream with a full FIFO
        gmode = 0; lat = 1; stall = 1'b1;
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; stall = 1'b0;
        chk1("midrst_id_valid", id_valid, 1'b0);
        chk32("midrst_id_inst", id_inst, 32'h13);
        chk32("midrst_addr", imem.imem_addr, RESET_PC);
        repeat (10) cycle();
        chk1("restart_valid", id_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
